// File: rtl/boiler_pour_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : boiler_pour_ctrl
//  Function : Cursor/select driven pour controller for a row of 4-layer
//             boilers, with move counting and solved detection.
//  Revision : 1.0 - initial release
// ============================================================================
module boiler_pour_ctrl #(
    parameter int NB = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_select,
    input  logic             load,
    input  logic [12*NB-1:0] init_layers,
    output logic [12*NB-1:0] layers,
    output logic [NB-1:0]    cursor_sel,
    output logic [NB-1:0]    src_sel,
    output logic             busy,
    output logic             err,
    output logic             solved,
    output logic [7:0]       move_count
);

    localparam int              c_cw       = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [c_cw-1:0] c_cur_last = c_cw'(NB - 1);
    localparam logic [c_cw-1:0] c_cur_one  = c_cw'(1);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_src_held = 3'd1;
    localparam logic [2:0] c_st_pour     = 3'd2;
    localparam logic [2:0] c_st_check    = 3'd3;
    localparam logic [2:0] c_st_solved   = 3'd4;

    logic [2:0]       r_state,   w_state_nxt;
    logic [12*NB-1:0] r_layers,  w_layers_nxt;
    logic [c_cw-1:0]  r_cursor,  w_cursor_nxt;
    logic [c_cw-1:0]  r_src,     w_src_nxt;
    logic             r_src_vld, w_src_vld_nxt;
    logic [c_cw-1:0]  r_dst,     w_dst_nxt;
    logic [2:0]       r_colour,  w_colour_nxt;
    logic             r_err,     w_err_nxt;
    logic [7:0]       r_moves,   w_moves_nxt;

    logic [11:0] w_src_bl, w_cur_bl, w_dst_bl;
    logic [2:0]  w_src_depth, w_cur_depth, w_dst_depth;
    logic [2:0]  w_src_top, w_cur_top;

    function automatic logic [11:0] f_boiler(input logic [12*NB-1:0] v, input logic [c_cw-1:0] idx);
        f_boiler = 12'd0;
        for (int b = 0; b < NB; b++)
            if (idx == c_cw'(b)) f_boiler = v[b*12 +: 12];
    endfunction

    // Contents are contiguous from the bottom, so depth = index of the highest liquid layer.
    function automatic logic [2:0] f_depth(input logic [11:0] bl);
        f_depth = 3'd0;
        for (int l = 0; l < 4; l++)
            if (bl[l*3 +: 3] != 3'd0) f_depth = 3'(l + 1);
    endfunction

    function automatic logic [2:0] f_top(input logic [11:0] bl);
        f_top = 3'd0;
        for (int l = 0; l < 4; l++)
            if (bl[l*3 +: 3] != 3'd0) f_top = bl[l*3 +: 3];
    endfunction

    function automatic logic f_sorted(input logic [12*NB-1:0] v);
        logic [11:0] bl;
        f_sorted = 1'b1;
        for (int b = 0; b < NB; b++) begin
            bl = v[b*12 +: 12];
            if (bl != 12'd0 && !(bl[2:0] != 3'd0 && bl[5:3] == bl[2:0] &&
                                 bl[8:6] == bl[2:0] && bl[11:9] == bl[2:0]))
                f_sorted = 1'b0;
        end
    endfunction

    assign w_src_bl    = f_boiler(r_layers, r_src);
    assign w_cur_bl    = f_boiler(r_layers, r_cursor);
    assign w_dst_bl    = f_boiler(r_layers, r_dst);
    assign w_src_depth = f_depth(w_src_bl);
    assign w_cur_depth = f_depth(w_cur_bl);
    assign w_dst_depth = f_depth(w_dst_bl);
    assign w_src_top   = f_top(w_src_bl);
    assign w_cur_top   = f_top(w_cur_bl);

    always_comb begin
        w_state_nxt   = r_state;
        w_layers_nxt  = r_layers;
        w_cursor_nxt  = r_cursor;
        w_src_nxt     = r_src;
        w_src_vld_nxt = r_src_vld;
        w_dst_nxt     = r_dst;
        w_colour_nxt  = r_colour;
        w_err_nxt     = 1'b0;
        w_moves_nxt   = r_moves;

        case (r_state)
            c_st_idle, c_st_src_held: begin
                // Select acts on the cursor as it was before any same-cycle move.
                if (btn_select) begin
                    if (r_state == c_st_idle) begin
                        if (w_cur_depth != 3'd0) begin
                            w_src_nxt     = r_cursor;
                            w_src_vld_nxt = 1'b1;
                            w_state_nxt   = c_st_src_held;
                        end
                    end else if (r_cursor == r_src) begin
                        w_src_vld_nxt = 1'b0;
                        w_state_nxt   = c_st_idle;
                    end else if (w_cur_depth != 3'd4 &&
                                 (w_cur_depth == 3'd0 || w_cur_top == w_src_top)) begin
                        w_dst_nxt    = r_cursor;
                        w_colour_nxt = w_src_top;
                        w_state_nxt  = c_st_pour;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_src_vld_nxt = 1'b0;
                        w_state_nxt   = c_st_idle;
                    end
                end
                if (btn_left && !btn_right)
                    w_cursor_nxt = (r_cursor == '0) ? c_cur_last : r_cursor - c_cur_one;
                else if (btn_right && !btn_left)
                    w_cursor_nxt = (r_cursor == c_cur_last) ? '0 : r_cursor + c_cur_one;
            end
            c_st_pour: begin
                if (w_src_top == r_colour && w_dst_depth != 3'd4) begin
                    for (int b = 0; b < NB; b++) begin
                        for (int l = 0; l < 4; l++) begin
                            if (r_src == c_cw'(b) && w_src_depth == 3'(l + 1))
                                w_layers_nxt[b*12 + l*3 +: 3] = 3'd0;
                            if (r_dst == c_cw'(b) && w_dst_depth == 3'(l))
                                w_layers_nxt[b*12 + l*3 +: 3] = r_colour;
                        end
                    end
                end else begin
                    w_state_nxt = c_st_check;
                end
            end
            c_st_check: begin
                if (r_moves != 8'hFF) w_moves_nxt = r_moves + 8'd1;
                w_src_vld_nxt = 1'b0;
                w_state_nxt   = f_sorted(r_layers) ? c_st_solved : c_st_idle;
            end
            c_st_solved: w_state_nxt = c_st_solved;
            default:     w_state_nxt = c_st_idle;
        endcase

        if (load) begin
            w_layers_nxt  = init_layers;
            w_cursor_nxt  = '0;
            w_src_vld_nxt = 1'b0;
            w_moves_nxt   = 8'd0;
            w_err_nxt     = 1'b0;
            w_state_nxt   = c_st_idle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_layers  <= '0;
            r_cursor  <= '0;
            r_src     <= '0;
            r_src_vld <= 1'b0;
            r_dst     <= '0;
            r_colour  <= 3'd0;
            r_err     <= 1'b0;
            r_moves   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_layers  <= w_layers_nxt;
            r_cursor  <= w_cursor_nxt;
            r_src     <= w_src_nxt;
            r_src_vld <= w_src_vld_nxt;
            r_dst     <= w_dst_nxt;
            r_colour  <= w_colour_nxt;
            r_err     <= w_err_nxt;
            r_moves   <= w_moves_nxt;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_sel
        assign cursor_sel[b] = (r_cursor == c_cw'(b));
        assign src_sel[b]    = r_src_vld && (r_src == c_cw'(b));
    end

    assign layers     = r_layers;
    assign busy       = (r_state == c_st_pour) || (r_state == c_st_check);
    assign err        = r_err;
    assign solved     = (r_state == c_st_solved);
    assign move_count = r_moves;

endmodule
`default_nettype wire

// File: tb/tb_boiler_pour_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boiler_pour_ctrl
//  Function : Self-checking bench for boiler_pour_ctrl: directed tables,
//             corner sequences and random stimulus against a pour-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boiler_pour_ctrl;

    localparam int NB = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             btn_left = 1'b0, btn_right = 1'b0, btn_select = 1'b0, load = 1'b0;
    logic [12*NB-1:0] init_layers = '0;
    logic [12*NB-1:0] layers;
    logic [NB-1:0]    cursor_sel, src_sel;
    logic             busy, err, solved;
    logic [7:0]       move_count;

    int vectors = 0;
    int miscompares = 0;

    boiler_pour_ctrl #(.NB(NB)) dut (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .btn_select(btn_select), .load(load), .init_layers(init_layers),
        .layers(layers), .cursor_sel(cursor_sel), .src_sel(src_sel),
        .busy(busy), .err(err), .solved(solved), .move_count(move_count)
    );

    always #5 clk = ~clk;

    // Pour-level reference: a whole pour is resolved at once and committed when busy ends.
    int m_lay [NB][4];
    int m_fin [NB][4];
    int m_cur, m_src, m_phase, m_busy_left, m_moves;
    logic m_err;

    function automatic int depth_of(input int b);
        int d = 0;
        for (int l = 0; l < 4; l++) if (m_lay[b][l] != 0) d = l + 1;
        return d;
    endfunction

    function automatic int top_of(input int b);
        int d = depth_of(b);
        return (d == 0) ? 0 : m_lay[b][d-1];
    endfunction

    function automatic bit fin_sorted();
        bit ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            bit empty = 1'b1, same = 1'b1;
            for (int l = 0; l < 4; l++) begin
                if (m_fin[b][l] != 0) empty = 1'b0;
                if (m_fin[b][l] != m_fin[b][0] || m_fin[b][l] == 0) same = 1'b0;
            end
            if (!empty && !same) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [12*NB-1:0] model_pack();
        logic [12*NB-1:0] v = '0;
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < 4; l++) v[b*12 + l*3 +: 3] = 3'(m_lay[b][l]);
        return v;
    endfunction

    function automatic logic [NB-1:0] onehot(input int i);
        logic [NB-1:0] v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [11:0] bl(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [12*NB-1:0] rand_puzzle();
        logic [12*NB-1:0] v = '0;
        int d;
        for (int b = 0; b < NB; b++) begin
            d = int'($urandom_range(0, 4));
            for (int l = 0; l < d; l++) v[b*12 + l*3 +: 3] = 3'($urandom_range(1, 3));
        end
        return v;
    endfunction

    task automatic model_edge(input logic l, input logic r, input logic s,
                              input logic ld, input logic rs, input logic [12*NB-1:0] init);
        int sd, dd, run, k, col;
        m_err = 1'b0;
        if (rs || ld) begin
            for (int b = 0; b < NB; b++)
                for (int j = 0; j < 4; j++) m_lay[b][j] = rs ? 0 : int'(init[b*12 + j*3 +: 3]);
            m_cur = 0; m_src = -1; m_phase = 0; m_moves = 0; m_busy_left = 0;
        end else if (m_phase == 2) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_lay = m_fin;
                if (m_moves < 255) m_moves++;
                m_src = -1;
                m_phase = fin_sorted() ? 3 : 0;
            end
        end else if (m_phase < 2) begin
            if (s) begin
                if (m_phase == 0) begin
                    if (depth_of(m_cur) > 0) begin m_src = m_cur; m_phase = 1; end
                end else if (m_cur == m_src) begin
                    m_src = -1; m_phase = 0;
                end else begin
                    sd = depth_of(m_src); dd = depth_of(m_cur); col = top_of(m_src);
                    if (dd < 4 && (dd == 0 || top_of(m_cur) == col)) begin
                        run = 0;
                        while (run < sd && m_lay[m_src][sd-1-run] == col) run++;
                        k = (run < 4 - dd) ? run : 4 - dd;
                        m_fin = m_lay;
                        for (int i = 0; i < k; i++) begin
                            m_fin[m_cur][dd+i]   = col;
                            m_fin[m_src][sd-1-i] = 0;
                        end
                        m_busy_left = k + 2;
                        m_phase = 2;
                    end else begin
                        m_err = 1'b1; m_src = -1; m_phase = 0;
                    end
                end
            end
            if (l && !r)      m_cur = (m_cur + NB - 1) % NB;
            else if (r && !l) m_cur = (m_cur + 1) % NB;
        end
    endtask

    task automatic check_model(input string nm);
        logic [12*NB-1:0] el = model_pack();
        logic [NB-1:0] ec = onehot(m_cur), es = onehot(m_src);
        logic eb = (m_phase == 2), eso = (m_phase == 3);
        vectors++;
        if ((m_phase != 2 && layers !== el) || cursor_sel !== ec || src_sel !== es ||
            busy !== eb || err !== m_err || solved !== eso || move_count !== 8'(m_moves)) begin
            miscompares++;
            $display("FAIL %s: got L=%h cur=%b src=%b busy=%b err=%b solved=%b moves=%0d, want L=%h cur=%b src=%b busy=%b err=%b solved=%b moves=%0d",
                     nm, layers, cursor_sel, src_sel, busy, err, solved, move_count,
                     el, ec, es, eb, m_err, eso, m_moves);
        end
    endtask

    task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic l, input logic r, input logic s, input logic ld,
                        input logic rs, input logic [12*NB-1:0] init, input string nm);
        btn_left = l; btn_right = r; btn_select = s; load = ld; reset = rs; init_layers = init;
        @(posedge clk);
        model_edge(l, r, s, ld, rs, init);
        #1;
        btn_left = 0; btn_right = 0; btn_select = 0; load = 0; reset = 0;
        check_model(nm);
    endtask

    task automatic press(input logic l, input logic r, input logic s, input string nm);
        step(l, r, s, 1'b0, 1'b0, '0, nm);
    endtask

    task automatic do_load(input logic [12*NB-1:0] v, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, nm);
    endtask

    typedef struct {
        logic          l, r, s;
        logic [NB-1:0] exp_cursor;
        logic [NB-1:0] exp_src;
    } vec_t;

    vec_t tbl [8];

    logic [12*NB-1:0] c_puz_a, c_puz_b, c_puz_c, c_puz_d;

    initial begin
        int bcnt;
        logic l, r, s, ld, rs;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'b0010, 4'b0000};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000};

        c_puz_a = {bl(0,0,0,0), bl(0,0,0,0), bl(2,0,0,0), bl(1,2,2,0)};
        c_puz_b = {bl(0,0,0,0), bl(0,0,0,0), bl(5,0,0,0), bl(3,0,0,0)};
        c_puz_c = {bl(0,0,0,0), bl(0,0,0,0), bl(6,6,4,0), bl(1,4,4,0)};
        c_puz_d = {bl(0,0,0,0), bl(1,0,0,0), bl(2,2,2,2), bl(1,1,1,0)};

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, "reset");
        check_val("reset_cursor", 64'(cursor_sel), 64'(4'b0001));
        check_val("reset_layers", 64'(layers), 64'd0);

        // Cursor wrap and button interaction table on an empty board.
        for (int i = 0; i < 8; i++) begin
            press(tbl[i].l, tbl[i].r, tbl[i].s, $sformatf("tbl%0d", i));
            check_val($sformatf("tbl%0d_cursor", i), 64'(cursor_sel), 64'(tbl[i].exp_cursor));
            check_val($sformatf("tbl%0d_src", i), 64'(src_sel), 64'(tbl[i].exp_src));
        end

        // Two-layer pour: b0 {1,2,2} onto b1 {2}.
        do_load(c_puz_a, "a_load");
        press(0, 0, 1, "a_sel_src");
        check_val("a_src_held", 64'(src_sel), 64'(4'b0001));
        press(0, 1, 0, "a_right");
        press(0, 0, 1, "a_sel_dst");
        bcnt = int'(busy);
        for (int i = 0; i < 8; i++) begin
            press(0, 0, 0, "a_wait");
            bcnt += int'(busy);
        end
        check_val("a_busy_cycles", 64'(bcnt), 64'd4);
        check_val("a_layers", 64'(layers), 64'({bl(0,0,0,0), bl(0,0,0,0), bl(2,2,2,0), bl(1,0,0,0)}));
        check_val("a_moves", 64'(move_count), 64'd1);

        // Rejected pour: colour 3 onto colour 5.
        do_load(c_puz_b, "b_load");
        press(0, 0, 1, "b_sel_src");
        press(0, 1, 0, "b_right");
        press(0, 0, 1, "b_sel_dst");
        check_val("b_err_pulse", 64'(err), 64'd1);
        press(0, 0, 0, "b_after");
        check_val("b_err_clear", 64'(err), 64'd0);
        check_val("b_layers", 64'(layers), 64'(c_puz_b));
        check_val("b_moves", 64'(move_count), 64'd0);

        // Destination with a single free slot takes exactly one layer.
        do_load(c_puz_c, "c_load");
        press(0, 0, 1, "c_sel_src");
        press(0, 1, 0, "c_right");
        press(0, 0, 1, "c_sel_dst");
        for (int i = 0; i < 5; i++) press(0, 0, 0, "c_wait");
        check_val("c_layers", 64'(layers), 64'({bl(0,0,0,0), bl(0,0,0,0), bl(6,6,4,4), bl(1,4,0,0)}));

        // Final pour solves the puzzle; buttons are then ignored until load.
        do_load(c_puz_d, "d_load");
        press(0, 1, 0, "d_r1");
        press(0, 1, 0, "d_r2");
        press(0, 0, 1, "d_sel_src");
        press(1, 0, 0, "d_l1");
        press(1, 0, 0, "d_l2");
        press(0, 0, 1, "d_sel_dst");
        for (int i = 0; i < 4; i++) press(0, 0, 0, "d_wait");
        check_val("d_solved", 64'(solved), 64'd1);
        press(1, 0, 1, "d_ignored1");
        press(0, 1, 0, "d_ignored2");
        check_val("d_cursor_frozen", 64'(cursor_sel), 64'(4'b0001));
        do_load(c_puz_a, "d_reload");
        check_val("d_solved_clear", 64'(solved), 64'd0);
        check_val("d_moves_clear", 64'(move_count), 64'd0);

        // Reset during the second pour cycle.
        press(0, 0, 1, "e_sel_src");
        press(0, 1, 0, "e_right");
        press(0, 0, 1, "e_sel_dst");
        press(0, 0, 0, "e_pour2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, "e_reset");
        check_val("e_outputs", 64'({layers, cursor_sel, src_sel, busy, err, solved, move_count}),
                  64'({48'd0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0}));

        // Random play against the model.
        do_load(rand_puzzle(), "rnd_load");
        for (int i = 0; i < 4000; i++) begin
            int p = int'($urandom_range(0, 199));
            rs = (p == 0);
            ld = (p >= 1 && p <= 6);
            l  = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 4) == 0);
            s  = ($urandom_range(0, 2) == 0);
            step(l, r, s, ld, rs, rand_puzzle(), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/boiler_pour_ctrl.md
BOILER_POUR_CTRL -- requirements
Module: boiler_pour_ctrl

Interface
REQ-001 SHALL provide parameter NB, default 4: number of boilers; each boiler holds 4 layers.
REQ-002 SHALL provide port clk  in  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL provide port btn_left  in  1  one-cycle pulse that moves the cursor left.
REQ-005 SHALL provide port btn_right  in  1  one-cycle pulse that moves the cursor right.
REQ-006 SHALL provide port btn_select  in  1  one-cycle pulse that selects the source or the destination boiler.
REQ-007 SHALL provide port load  in  1  one-cycle pulse that loads a new puzzle.
REQ-008 SHALL provide port init_layers  in  12*NB  puzzle contents, sampled when load=1.
REQ-009 SHALL provide port layers  out  12*NB  current contents; boiler b, layer l (1=bottom..4=top) at bits [b*12+(l-1)*3 +: 3].
REQ-010 SHALL provide port cursor_sel  out  NB  one-hot cursor position; drives the renderer's selected input.
REQ-011 SHALL provide port src_sel  out  NB  one-hot held source boiler; all zero when no source is held.
REQ-012 SHALL provide port busy  out  1  high while the state is POUR or CHECK.
REQ-013 SHALL provide port err  out  1  one-cycle pulse on a rejected pour.
REQ-014 SHALL provide port solved  out  1  high while the state is SOLVED.
REQ-015 SHALL provide port move_count  out  8  count of completed pours, saturating at 255.

Function
REQ-016 SHALL treat colour code 3'b000 as empty, codes 001-110 as liquid, and 111 as invalid; 111 is never written by a pour.
REQ-017 SHALL keep every boiler's contents contiguous from layer 1 upward; top = highest non-empty layer.
REQ-018 SHALL implement states IDLE, SRC_HELD, POUR, CHECK and SOLVED.
REQ-019 SHALL, in IDLE and SRC_HELD only, move the cursor on btn_left (-1) and btn_right (+1) modulo NB, wrapping between 0 and NB-1.
REQ-020 SHALL leave the cursor unchanged when btn_left and btn_right are asserted in the same cycle.
REQ-021 SHALL apply btn_select before the cursor move when it coincides with btn_left or btn_right, using the pre-move cursor.
REQ-022 SHALL, in IDLE, on btn_select with the cursor boiler non-empty, latch it as source and go to SRC_HELD next cycle.
REQ-023 SHALL, in IDLE, ignore btn_select when the cursor boiler is empty.
REQ-024 SHALL, in SRC_HELD, on btn_select with the cursor equal to the source, deselect and return to IDLE with no err and no count change.
REQ-025 SHALL, in SRC_HELD, on btn_select with the cursor at another boiler, accept the pour if the destination is not full and is empty or has a top colour equal to the source top colour.
REQ-026 SHALL go to POUR on an accepted pour; otherwise it SHALL pulse err for one cycle, clear the source and return to IDLE.
REQ-027 SHALL, in each POUR cycle, move one layer from source top to destination top if the source top equals the pour colour latched at entry and the destination is not full; otherwise it SHALL go to CHECK.
REQ-028 SHALL take k+1 POUR cycles to move k layers (k≥1).
REQ-029 SHALL, in CHECK (one cycle), increment move_count (saturating) and clear the source.
REQ-030 SHALL then go to SOLVED if every boiler is all-empty or holds 4 identical non-empty layers, else to IDLE.
REQ-031 SHALL ignore all buttons in POUR, CHECK and SOLVED.
REQ-032 SHALL, on load in any state, copy init_layers to layers, clear the source, zero move_count and cursor, and enter IDLE next cycle; load takes priority over buttons and over an in-progress pour.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, set all layers to 000, cursor_sel=1 (boiler 0), src_sel=0, move_count=0, busy=0, err=0, solved=0 and state IDLE.
REQ-034 SHALL give reset priority over load and all buttons, including when reset is asserted mid-POUR.

Verification
REQ-035 SHALL cover: reset, then btn_left -> cursor_sel=4'b1000 (wrap); then btn_right ×2 -> cursor_sel=4'b0010.
REQ-036 SHALL cover: load b0={1,2,2,0}, b1={2,0,0,0}; select b0, select b1 -> 3 POUR cycles, b0={1,0,0,0}, b1={2,2,2,0}, move_count=1, busy high 4 cycles.
REQ-037 SHALL cover: source top colour 3 onto destination top colour 5 -> err pulses 1 cycle, layers unchanged, move_count=0, state IDLE.
REQ-038 SHALL cover: source with top {4,4} onto a destination with 1 free slot -> exactly one layer moved, the source keeps one 4.
REQ-039 SHALL cover: a final pour completing b0={1,1,1,1}, b1={2,2,2,2}, rest empty -> solved=1; buttons ignored; load -> solved=0, move_count=0.
REQ-040 SHALL cover: reset asserted on the 2nd POUR cycle -> all outputs at reset values next cycle.
